// File: rtl/ysyx_23060077_gpr_bank_pkg.sv
// ysyx_23060077_gpr_bank_pkg: shared width defaults and the hard-wired zero-register address
package ysyx_23060077_gpr_bank_pkg;
    localparam int GPR_DATA_WIDTH = 32;
    localparam int GPR_REG_WIDTH  = 5;
    localparam int GPR_ZERO_ADDR  = 0;
endpackage

// File: rtl/ysyx_23060077_gpr_rdport.sv
// ysyx_23060077_gpr_rdport: one register-file read port with busy lookup and optional write bypass
// Ports: addr_i read address; regs_i/busy_i register array and scoreboard; wr_*_i write ports
//        (used only for bypass); data_o read data; busy_o pending-producer flag.
// Config: YSYX_23060077_GPR_BYPASS_EN forwards same-cycle write data to the read.
module ysyx_23060077_gpr_rdport
    import ysyx_23060077_gpr_bank_pkg::*;
#(
    parameter int DATA_WIDTH = GPR_DATA_WIDTH,
    parameter int REG_WIDTH  = GPR_REG_WIDTH,
    parameter int NUM_WR     = 2
) (
    input  logic [REG_WIDTH-1:0]                        addr_i,
    input  logic [2**REG_WIDTH-1:0][DATA_WIDTH-1:0]     regs_i,
    input  logic [2**REG_WIDTH-1:0]                     busy_i,
    input  logic [NUM_WR-1:0]                           wr_en_i,
    input  logic [NUM_WR*REG_WIDTH-1:0]                 wr_addr_i,
    input  logic [NUM_WR*DATA_WIDTH-1:0]                wr_data_i,
    output logic [DATA_WIDTH-1:0]                       data_o,
    output logic                                        busy_o
);
    localparam logic [REG_WIDTH-1:0] ZERO = REG_WIDTH'(GPR_ZERO_ADDR);
`ifdef YSYX_23060077_GPR_BYPASS_EN
    logic hit;
    // later ports overwrite earlier matches so the highest enabled index wins
    always_comb begin
        data_o = regs_i[addr_i];
        hit    = 1'b0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en_i[j] && addr_i != ZERO && wr_addr_i[j*REG_WIDTH +: REG_WIDTH] == addr_i) begin
                data_o = wr_data_i[j*DATA_WIDTH +: DATA_WIDTH];
                hit    = 1'b1;
            end
        end
    end
    assign busy_o = busy_i[addr_i] & ~hit;
`else
    logic unused_wr;
    assign unused_wr = ^{wr_en_i, wr_addr_i, wr_data_i};
    assign data_o    = (addr_i == ZERO) ? '0 : regs_i[addr_i];
    assign busy_o    = (addr_i != ZERO) & busy_i[addr_i];
`endif
endmodule

// File: rtl/ysyx_23060077_gpr_bank.sv
// ysyx_23060077_gpr_bank: multi-port GPR file with a per-register WAW scoreboard
// Ports: clock/reset (async active-low); rd_addr/rd_data/rd_busy read ports; wr_en/wr_addr/wr_data
//        write ports (highest index wins); alloc_en/alloc_addr/alloc_ready destination claim;
//        busy_vec scoreboard. x0 is hard-wired zero and never busy.
// Config: YSYX_23060077_GPR_BYPASS_EN enables same-cycle write-to-read forwarding.
module ysyx_23060077_gpr_bank
    import ysyx_23060077_gpr_bank_pkg::*;
#(
    parameter int DATA_WIDTH = GPR_DATA_WIDTH,
    parameter int REG_WIDTH  = GPR_REG_WIDTH,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_RD*REG_WIDTH-1:0]     rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]    rd_data,
    output logic [NUM_RD-1:0]               rd_busy,
    input  logic [NUM_WR-1:0]               wr_en,
    input  logic [NUM_WR*REG_WIDTH-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0]    wr_data,
    input  logic                            alloc_en,
    input  logic [REG_WIDTH-1:0]            alloc_addr,
    output logic                            alloc_ready,
    output logic [2**REG_WIDTH-1:0]         busy_vec
);
    localparam int REG_COUNT = 2**REG_WIDTH;
    localparam logic [REG_WIDTH-1:0] ZERO = REG_WIDTH'(GPR_ZERO_ADDR);
    logic [REG_COUNT-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [REG_COUNT-1:0]                 busy_q, busy_d;
    assign alloc_ready = (alloc_addr == ZERO) || !busy_q[alloc_addr];
    assign busy_vec    = busy_q;
    // writes clear claims first, then an accepted claim sets, so a same-cycle claim wins
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j]) begin
                regs_d[wr_addr[j*REG_WIDTH +: REG_WIDTH]] = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
                busy_d[wr_addr[j*REG_WIDTH +: REG_WIDTH]] = 1'b0;
            end
        end
        if (alloc_en && alloc_ready) busy_d[alloc_addr] = 1'b1;
        regs_d[ZERO] = '0;
        busy_d[ZERO] = 1'b0;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        ysyx_23060077_gpr_rdport #(
            .DATA_WIDTH (DATA_WIDTH),
            .REG_WIDTH  (REG_WIDTH),
            .NUM_WR     (NUM_WR)
        ) u_rdport (
            .addr_i    (rd_addr[k*REG_WIDTH +: REG_WIDTH]),
            .regs_i    (regs_q),
            .busy_i    (busy_q),
            .wr_en_i   (wr_en),
            .wr_addr_i (wr_addr),
            .wr_data_i (wr_data),
            .data_o    (rd_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .busy_o    (rd_busy[k])
        );
    end
endmodule

// File: tb/tb_ysyx_23060077_gpr_bank.sv
// tb_ysyx_23060077_gpr_bank: directed and random checks of the GPR bank against an array model
module tb_ysyx_23060077_gpr_bank;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int RC = 32;
    logic               clock = 1'b0;
    logic               reset;
    logic [NR*RW-1:0]   rd_addr;
    logic [NR*DW-1:0]   rd_data;
    logic [NR-1:0]      rd_busy;
    logic [NW-1:0]      wr_en;
    logic [NW*RW-1:0]   wr_addr;
    logic [NW*DW-1:0]   wr_data;
    logic               alloc_en;
    logic [RW-1:0]      alloc_addr;
    logic               alloc_ready;
    logic [RC-1:0]      busy_vec;
    logic [DW-1:0]      m_regs [RC];
    bit                 m_busy [RC];
    int                 n_checks = 0;
    int                 n_fail   = 0;
    bit                 bypass;

    ysyx_23060077_gpr_bank #(.DATA_WIDTH(DW), .REG_WIDTH(RW), .NUM_RD(NR), .NUM_WR(NW)) dut (
        .clock       (clock),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .alloc_en    (alloc_en),
        .alloc_addr  (alloc_addr),
        .alloc_ready (alloc_ready),
        .busy_vec    (busy_vec)
    );

    always #5 clock = ~clock;

    task automatic expect_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input int r0, input int r1, input logic [1:0] we, input int wa0, input int wa1,
                          input logic [DW-1:0] wd0, input logic [DW-1:0] wd1, input bit ae, input int aa);
        rd_addr    = {RW'(r1), RW'(r0)};
        wr_en      = we;
        wr_addr    = {RW'(wa1), RW'(wa0)};
        wr_data    = {wd1, wd0};
        alloc_en   = ae;
        alloc_addr = RW'(aa);
    endtask

    task automatic model_reset();
        for (int i = 0; i < RC; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // register-file semantics: writes land in port order, then a claim is judged on the pre-edge scoreboard
    task automatic model_clock();
        bit old [RC];
        old = m_busy;
        for (int j = 0; j < NW; j++) begin
            int a;
            a = int'(wr_addr[j*RW +: RW]);
            if (wr_en[j] && a != 0) begin
                m_regs[a] = wr_data[j*DW +: DW];
                m_busy[a] = 1'b0;
            end
        end
        if (alloc_en && alloc_addr != 0 && !old[alloc_addr]) m_busy[alloc_addr] = 1'b1;
    endtask

    task automatic check_outputs();
        logic [RC-1:0] bv;
        for (int k = 0; k < NR; k++) begin
            int a;
            logic [DW-1:0] ed;
            bit eb;
            a  = int'(rd_addr[k*RW +: RW]);
            ed = m_regs[a];
            eb = m_busy[a];
            if (bypass && a != 0)
                for (int j = 0; j < NW; j++)
                    if (wr_en[j] && int'(wr_addr[j*RW +: RW]) == a) begin
                        ed = wr_data[j*DW +: DW];
                        eb = 1'b0;
                    end
            if (a == 0) begin
                ed = '0;
                eb = 1'b0;
            end
            expect_eq($sformatf("rd_data[%0d] x%0d", k, a), 64'(rd_data[k*DW +: DW]), 64'(ed));
            expect_eq($sformatf("rd_busy[%0d] x%0d", k, a), 64'(rd_busy[k]), 64'(eb));
        end
        for (int i = 0; i < RC; i++) bv[i] = m_busy[i];
        expect_eq("busy_vec", 64'(busy_vec), 64'(bv));
        expect_eq("alloc_ready", 64'(alloc_ready), 64'(alloc_addr == 0 || !m_busy[alloc_addr]));
    endtask

    task automatic settle();
        #1;
        check_outputs();
    endtask

    task automatic tick();
        @(posedge clock);
        model_clock();
        @(negedge clock);
    endtask

    initial begin
`ifdef YSYX_23060077_GPR_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        model_reset();
        reset = 1'b0;
        set_in(5, 0, 2'b01, 5, 0, 32'h1234, 0, 1'b1, 5);
        @(posedge clock);
        #1;
        expect_eq("reset rd x5", 64'(rd_data[DW-1:0]), 64'h0);
        expect_eq("reset busy_vec", 64'(busy_vec), 64'h0);
        expect_eq("reset alloc_ready", 64'(alloc_ready), 64'h1);
        @(negedge clock);
        reset = 1'b1;
        set_in(5, 5, 2'b00, 0, 0, 0, 0, 1'b0, 5);
        settle();
        expect_eq("post-reset rd x5", 64'(rd_data[DW-1:0]), 64'h0);
        tick();
        set_in(7, 0, 2'b11, 7, 7, 32'hAAAA, 32'h5555, 1'b0, 0);
        settle();
        tick();
        set_in(7, 7, 2'b00, 0, 0, 0, 0, 1'b0, 0);
        settle();
        expect_eq("conflict x7", 64'(rd_data[DW-1:0]), 64'h5555);
        tick();
        set_in(0, 0, 2'b01, 0, 0, 32'hFFFF_FFFF, 0, 1'b1, 0);
        settle();
        tick();
        set_in(0, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);
        settle();
        expect_eq("x0 data", 64'(rd_data[DW-1:0]), 64'h0);
        expect_eq("x0 busy", 64'(busy_vec[0]), 64'h0);
        expect_eq("x0 alloc_ready", 64'(alloc_ready), 64'h1);
        tick();
        set_in(3, 0, 2'b00, 0, 0, 0, 0, 1'b1, 3);
        settle();
        tick();
        set_in(3, 3, 2'b00, 0, 0, 0, 0, 1'b1, 3);
        settle();
        expect_eq("claim x3 busy", 64'(busy_vec[3]), 64'h1);
        expect_eq("claim x3 stall", 64'(alloc_ready), 64'h0);
        expect_eq("claim x3 rd_busy", 64'(rd_busy[0]), 64'h1);
        tick();
        set_in(3, 0, 2'b10, 0, 3, 0, 32'h33, 1'b0, 3);
        settle();
        tick();
        set_in(3, 0, 2'b00, 0, 0, 0, 0, 1'b0, 3);
        settle();
        expect_eq("write clears x3", 64'(busy_vec[3]), 64'h0);
        tick();
        set_in(4, 0, 2'b01, 4, 0, 32'h44, 0, 1'b1, 4);
        settle();
        tick();
        set_in(4, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);
        settle();
        expect_eq("claim beats clear x4", 64'(busy_vec[4]), 64'h1);
        tick();
        set_in(9, 0, 2'b01, 9, 0, 32'h1111, 0, 1'b0, 0);
        settle();
        tick();
        set_in(9, 0, 2'b00, 0, 0, 0, 0, 1'b1, 9);
        settle();
        tick();
        set_in(9, 9, 2'b01, 9, 0, 32'hBEEF, 0, 1'b0, 0);
        settle();
        expect_eq("bypass x9 data", 64'(rd_data[DW-1:0]), bypass ? 64'hBEEF : 64'h1111);
        expect_eq("bypass x9 busy", 64'(rd_busy[0]), bypass ? 64'h0 : 64'h1);
        tick();
        set_in(9, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);
        settle();
        expect_eq("x9 next cycle", 64'(rd_data[DW-1:0]), 64'hBEEF);
        expect_eq("x9 next busy", 64'(rd_busy[0]), 64'h0);
        tick();
        for (int c = 0; c < 3000; c++) begin
            set_in($urandom_range(0, 15), $urandom_range(0, 15), 2'($urandom_range(0, 3)),
                   $urandom_range(0, 15), $urandom_range(0, 15), $urandom, $urandom,
                   1'($urandom_range(0, 1)), $urandom_range(0, 15));
            settle();
            tick();
        end
        set_in(1, 2, 2'b00, 0, 0, 0, 0, 1'b0, 1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        expect_eq("async reset busy_vec", 64'(busy_vec), 64'h0);
        check_outputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
